// File: rtl/pu_rf_wb.sv
// Write-back arbiter for the PU register file: merges single-cycle ALU results with
// buffered out-of-order load responses, and keeps the per-register load-pending scoreboard.
module pu_rf_wb #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 5,
  parameter int LQ_NBITS    = 2,
  parameter int STARVE_LIM  = 4,
  parameter logic [(1<<DEPTH_NBITS)-1:0] PROT_MASK = 32'h8007FF00
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        alu_wr_valid,
  input  logic [DEPTH_NBITS-1:0]      alu_waddr,
  input  logic [WIDTH-1:0]            alu_wdata,
  input  logic                        ld_issue,
  input  logic [DEPTH_NBITS-1:0]      ld_issue_addr,
  input  logic                        ld_rsp_valid,
  output logic                        ld_rsp_ready,
  input  logic [DEPTH_NBITS-1:0]      ld_rsp_addr,
  input  logic [WIDTH-1:0]            ld_rsp_data,
  output logic                        rf_wr,
  output logic [DEPTH_NBITS-1:0]      rf_waddr,
  output logic [WIDTH-1:0]            rf_din,
  output logic [(1<<DEPTH_NBITS)-1:0] pend,
  output logic                        alu_stall,
  output logic                        prot_err,
  output logic                        ld_dup_err
);
  localparam int DEPTH    = 1 << DEPTH_NBITS;
  localparam int LQ_DEPTH = 1 << LQ_NBITS;
  localparam int SC_W     = $clog2(STARVE_LIM) + 1;
  localparam logic [LQ_NBITS:0] LQ_FULL = (LQ_NBITS+1)'(LQ_DEPTH);
  localparam logic [SC_W-1:0]   SC_LIM  = SC_W'(STARVE_LIM - 1);
  localparam logic [SC_W-1:0]   SC_MAX  = {SC_W{1'b1}};

  logic [DEPTH_NBITS-1:0] lq_addr_mem [LQ_DEPTH];
  logic [WIDTH-1:0]       lq_data_mem [LQ_DEPTH];

  logic [LQ_NBITS-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LQ_NBITS:0]      count_reg, count_next;
  logic [SC_W-1:0]        starve_cnt_reg, starve_cnt_next;
  logic                   alu_stall_reg, alu_stall_next;
  logic                   rf_wr_reg, prot_err_reg, ld_dup_err_reg;
  logic [DEPTH_NBITS-1:0] rf_waddr_reg;
  logic [WIDTH-1:0]       rf_din_reg;
  logic [DEPTH-1:0]       pend_reg, pend_next;

  logic                   lq_full, lq_empty, lq_push;
  logic                   sel_alu, sel_ld, sel_any, sel_prot;
  logic [DEPTH_NBITS-1:0] head_addr, sel_addr;
  logic [WIDTH-1:0]       head_data, sel_data;

  // Readiness is taken from the registered count only, so a pop never frees a slot same-cycle.
  assign lq_full   = (count_reg == LQ_FULL);
  assign lq_empty  = (count_reg == '0);
  assign lq_push   = ld_rsp_valid & ~lq_full;
  assign head_addr = lq_addr_mem[rd_ptr_reg];
  assign head_data = lq_data_mem[rd_ptr_reg];

  assign sel_alu  = alu_wr_valid & ~alu_stall_reg;
  assign sel_ld   = ~sel_alu & ~lq_empty;
  assign sel_any  = sel_alu | sel_ld;
  assign sel_addr = sel_alu ? alu_waddr : head_addr;
  assign sel_data = sel_alu ? alu_wdata : head_data;
  assign sel_prot = PROT_MASK[sel_addr];

  always_comb begin
    count_next = count_reg;
    if (lq_push && !sel_ld)
      count_next = count_reg + 1'b1;
    else if (!lq_push && sel_ld)
      count_next = count_reg - 1'b1;
  end

  // The stall cycle guarantees a pop, so alu_stall self-clears one cycle later.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (sel_ld)
      starve_cnt_next = '0;
    else if (lq_full && starve_cnt_reg != SC_MAX)
      starve_cnt_next = starve_cnt_reg + 1'b1;
    alu_stall_next = lq_full & ~sel_ld & (starve_cnt_reg >= SC_LIM);
  end

  // A new issue wins over a retiring load to the same register.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign pend_next[gi] = (ld_issue && ld_issue_addr == DEPTH_NBITS'(gi)) |
                             (pend_reg[gi] & ~(sel_ld && head_addr == DEPTH_NBITS'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (lq_push) begin
      lq_addr_mem[wr_ptr_reg] <= ld_rsp_addr;
      lq_data_mem[wr_ptr_reg] <= ld_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
      alu_stall_reg  <= 1'b0;
      rf_wr_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_din_reg     <= '0;
      pend_reg       <= '0;
      prot_err_reg   <= 1'b0;
      ld_dup_err_reg <= 1'b0;
    end else begin
      if (lq_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (sel_ld)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      starve_cnt_reg <= starve_cnt_next;
      alu_stall_reg  <= alu_stall_next;
      rf_wr_reg      <= sel_any & ~sel_prot;
      prot_err_reg   <= sel_any & sel_prot;
      if (sel_any) begin
        rf_waddr_reg <= sel_addr;
        rf_din_reg   <= sel_data;
      end
      pend_reg       <= pend_next;
      ld_dup_err_reg <= ld_issue & pend_reg[ld_issue_addr];
    end
  end

  assign ld_rsp_ready = ~lq_full;
  assign rf_wr        = rf_wr_reg;
  assign rf_waddr     = rf_waddr_reg;
  assign rf_din       = rf_din_reg;
  assign pend         = pend_reg;
  assign alu_stall    = alu_stall_reg;
  assign prot_err     = prot_err_reg;
  assign ld_dup_err   = ld_dup_err_reg;
endmodule

// File: tb/tb_pu_rf_wb.sv
// Bench for pu_rf_wb: table of single-cycle vectors, then hand sequences for load latency,
// hazards, protection, starvation and mid-stream reset, all backed by an expected-write queue.
module tb_pu_rf_wb;
  localparam logic [31:0] PROT = 32'h8007FF00;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        alu_wr_valid, ld_issue, ld_rsp_valid;
  logic [4:0]  alu_waddr, ld_issue_addr, ld_rsp_addr;
  logic [31:0] alu_wdata, ld_rsp_data;
  logic        ld_rsp_ready, rf_wr, alu_stall, prot_err, ld_dup_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_din, pend;

  pu_rf_wb dut (
    .clk(clk), .rstn(rstn),
    .alu_wr_valid(alu_wr_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
    .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
    .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_din(rf_din), .pend(pend),
    .alu_stall(alu_stall), .prot_err(prot_err), .ld_dup_err(ld_dup_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        iss;
    logic [4:0]  iss_a;
    logic        exp_wr;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_prot;
    logic        exp_dup;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs [10];
  wr_t  exp_q [$];
  wr_t  lq_m [$];
  int   total = 0;
  int   bad = 0;
  int   prot_seen, wr_seen;
  logic acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_wr_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    ld_issue = 1'b0; ld_issue_addr = '0;
    ld_rsp_valid = 1'b0; ld_rsp_addr = '0; ld_rsp_data = '0;
  endtask

  // One clock: predict this cycle's selection, push the expected write, then compare after the edge.
  task automatic cyc();
    logic sel_alu, pushed, exp_prot;
    wr_t  w, got;
    pushed = 1'b0;
    exp_prot = 1'b0;
    w = '0;
    chk("ld_rsp_ready", 64'(ld_rsp_ready), 64'(lq_m.size() != 4));
    acc = ld_rsp_valid && (lq_m.size() != 4);
    sel_alu = alu_wr_valid && !alu_stall;
    if (sel_alu || lq_m.size() != 0) begin
      if (sel_alu) begin
        w.addr = alu_waddr;
        w.data = alu_wdata;
      end else begin
        w = lq_m.pop_front();
      end
      if (PROT[w.addr]) exp_prot = 1'b1;
      else begin
        exp_q.push_back(w);
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      w.addr = ld_rsp_addr;
      w.data = ld_rsp_data;
      lq_m.push_back(w);
    end
    if (rf_wr) wr_seen++;
    if (prot_err) prot_seen++;
    chk("rf_wr", 64'(rf_wr), 64'(pushed));
    chk("prot_err", 64'(prot_err), 64'(exp_prot));
    if (pushed) begin
      got = exp_q.pop_front();
      if (rf_wr) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(got.addr));
        chk("rf_din", 64'(rf_din), 64'(got.data));
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rf_wr"}, 64'(rf_wr), 64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_rf_din"}, 64'(rf_din), 64'd0);
    chk({tag, "_pend"}, 64'(pend), 64'd0);
    chk({tag, "_alu_stall"}, 64'(alu_stall), 64'd0);
    chk({tag, "_prot_err"}, 64'(prot_err), 64'd0);
    chk({tag, "_ld_dup_err"}, 64'(ld_dup_err), 64'd0);
    chk({tag, "_ld_rsp_ready"}, 64'(ld_rsp_ready), 64'd1);
  endtask

  initial begin
    int k, j;
    logic stall_now;
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd9,  32'h11,       1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 5'd0,  32'hCAFE,     1'b0, 5'd0, 1'b1, 5'd0,  32'hCAFE,     1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h80};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h80};
    vecs[6] = '{1'b1, 5'd31, 32'h5,        1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h90};
    vecs[7] = '{1'b1, 5'd18, 32'h18,       1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h90};
    vecs[8] = '{1'b1, 5'd19, 32'h1919,     1'b0, 5'd0, 1'b1, 5'd19, 32'h1919,     1'b0, 1'b0, 32'h90};
    vecs[9] = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0, 32'h90};

    idle();
    prot_seen = 0;
    wr_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("init");
    #3 rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      idle();
      alu_wr_valid = vecs[i].alu_v; alu_waddr = vecs[i].alu_a; alu_wdata = vecs[i].alu_d;
      ld_issue = vecs[i].iss; ld_issue_addr = vecs[i].iss_a;
      cyc();
      chk($sformatf("vec%0d_wr", i), 64'(rf_wr), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        chk($sformatf("vec%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].exp_a));
        chk($sformatf("vec%0d_din", i), 64'(rf_din), 64'(vecs[i].exp_d));
      end
      chk($sformatf("vec%0d_prot", i), 64'(prot_err), 64'(vecs[i].exp_prot));
      chk($sformatf("vec%0d_dup", i), 64'(ld_dup_err), 64'(vecs[i].exp_dup));
      chk($sformatf("vec%0d_pend", i), 64'(pend), 64'(vecs[i].exp_pend));
      chk($sformatf("vec%0d_stall", i), 64'(alu_stall), 64'd0);
    end

    // Load path: issue reg 3, response accepted at N, rf_wr and pend clear at N+2.
    idle(); ld_issue = 1'b1; ld_issue_addr = 5'd3;
    cyc();
    chk("ld_pend_set", 64'(pend), 64'h98);
    idle(); ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd3; ld_rsp_data = 32'h1234;
    cyc();
    chk("ld_n1_wr", 64'(rf_wr), 64'd0);
    chk("ld_n1_pend3", 64'(pend[3]), 64'd1);
    idle();
    cyc();
    chk("ld_n2_wr", 64'(rf_wr), 64'd1);
    chk("ld_n2_din", 64'(rf_din), 64'h1234);
    chk("ld_n2_pend3", 64'(pend[3]), 64'd0);

    // Same-cycle issue and pop for reg 7: set wins, and it is a duplicate issue.
    idle(); ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd7; ld_rsp_data = 32'h7777;
    cyc();
    idle(); ld_issue = 1'b1; ld_issue_addr = 5'd7;
    cyc();
    chk("haz_pend7", 64'(pend[7]), 64'd1);
    chk("haz_dup", 64'(ld_dup_err), 64'd1);
    idle();
    cyc();
    chk("haz_dup_pulse", 64'(ld_dup_err), 64'd0);

    // Protection: ALU to reg 9, then load to reg 31.
    prot_seen = 0; wr_seen = 0;
    idle(); alu_wr_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h9999;
    cyc();
    idle(); ld_issue = 1'b1; ld_issue_addr = 5'd31;
    cyc();
    chk("prot_pend31_set", 64'(pend[31]), 64'd1);
    idle(); ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd31; ld_rsp_data = 32'h3131;
    cyc();
    idle();
    repeat (2) cyc();
    chk("prot_pulses", 64'(prot_seen), 64'd2);
    chk("prot_no_wr", 64'(wr_seen), 64'd0);
    chk("prot_pend31_clr", 64'(pend[31]), 64'd0);

    // Starvation: ALU valid every cycle while four responses fill the queue.
    k = 0; j = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      alu_wr_valid = (c < 14);
      alu_waddr = 5'(1 + (k % 6));
      alu_wdata = 32'hA000_0000 + 32'(k);
      ld_rsp_valid = (j < 4);
      ld_rsp_addr = 5'(20 + j);
      ld_rsp_data = 32'hB000_0000 + 32'(j);
      stall_now = alu_stall;
      chk($sformatf("starve_stall_c%0d", c), 64'(alu_stall), 64'(c == 8));
      if (c >= 4 && c <= 8)
        chk($sformatf("starve_ready_c%0d", c), 64'(ld_rsp_ready), 64'd0);
      cyc();
      if (acc) j++;
      if (alu_wr_valid && !stall_now) k++;
    end
    chk("starve_alu_consumed", 64'(k), 64'd13);
    chk("starve_drained_ready", 64'(ld_rsp_ready), 64'd1);

    // Reset mid-stream with three responses queued behind a busy ALU.
    for (int c = 0; c < 3; c++) begin
      idle();
      alu_wr_valid = 1'b1; alu_waddr = 5'(2 + c); alu_wdata = 32'hC000_0000 + 32'(c);
      ld_rsp_valid = 1'b1; ld_rsp_addr = 5'(24 + c); ld_rsp_data = 32'hD000_0000 + 32'(c);
      ld_issue = (c == 0); ld_issue_addr = 5'd12;
      cyc();
    end
    chk("rst_pre_pend12", 64'(pend[12]), 64'd1);
    idle();
    rstn = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    lq_m.delete();
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_wr", 64'(rf_wr), 64'd0);
    end
    #3 rstn = 1'b1;
    wr_seen = 0;
    repeat (6) cyc();
    chk("rst_no_wr_after", 64'(wr_seen), 64'd0);
    chk("rst_pend_after", 64'(pend), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
